aes_arbiter: RTL

AES_ARBITER -- requirements
Module: aes_arbiter

---
 rtl/ot_pkg.sv | 29 ++
 rtl/aes_tag_pipe.sv | 63 ++++++
 rtl/aes_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ot_pkg.sv
// -----------------------------------------------------------------------------
// ot_pkg -- shared types and constants for the AES arbiter slice.
//
// Contents:
//   port_e              requester identity (EXPAND engine = 0, HASH engine = 1)
//   AES_LATENCY_DEFAULT default AES pipe depth in cycles
//   TAG_W_MAX           widest requester tag the tag-pipe entry can carry
//   tag_entry_t         payload that travels alongside each AES block; its
//                       valid bit rides in the tag pipe's own valid chain
// -----------------------------------------------------------------------------
package ot_pkg;

    typedef enum logic {
        EXPAND = 1'b0,
        HASH   = 1'b1
    } port_e;

    localparam int AES_LATENCY_DEFAULT = 29;

    // The arbiter's tag parameter D must not exceed this; narrower tags are
    // zero-padded into the entry.
    localparam int TAG_W_MAX = 8;

    typedef struct packed {
        port_e                port;
        logic [TAG_W_MAX-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/aes_tag_pipe.sv
// -----------------------------------------------------------------------------
// aes_tag_pipe -- fixed-depth shift register carrying a valid bit and a
// WIDTH-bit payload, advanced every cycle.
//
// Parameters:
//   DEPTH  number of stages (>= 1)
//   WIDTH  payload width
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset (clears valid bits only)
//   in_valid   valid bit entering stage 0
//   in_data    payload entering stage 0
//   out_valid  valid bit of the last stage
//   out_data   payload of the last stage
//   any_valid  high while any stage holds a valid entry
// -----------------------------------------------------------------------------
module aes_tag_pipe
    import ot_pkg::*;
#(
    parameter int DEPTH = AES_LATENCY_DEFAULT,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             any_valid
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value; blocking here would collapse
    // the whole shift register into a single stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // NOTE: the payload array is deliberately not reset -- its contents are
    // only ever qualified by the matching valid bit, and leaving it out of
    // the reset keeps it mappable to plain flops or shift-register cells.
    always_ff @(posedge clk) begin
        dat[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
            dat[i] <= dat[i-1];
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
    assign any_valid = |vld;

endmodule

// File: rtl/aes_arbiter.sv
// -----------------------------------------------------------------------------
// aes_arbiter -- shares one fixed-latency AES pipe between the EXPAND engine
// (port 0) and the HASH engine (port 1), returning each result to its owner
// together with the owner's write tag.
//
// Build option:
//   AES_ARB_ROUND_ROBIN_EN  defined   -> round-robin between the two ports
//                           undefined -> fixed priority, port 0 always wins
//
// Parameters:
//   D            tag width in bits (1..TAG_W_MAX)
//   DATA_W       AES block width
//   AES_LATENCY  cycles from AES input to AES output
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   enable                        permits new grants
//   reqN_valid/ready/data/tag     request handshake per port (ready is
//                                 combinational)
//   aes_in_valid/aes_in_data      registered issue into the AES pipe
//   aes_out_valid/aes_out_data    AES pipe result
//   rspN_valid/data/tag           registered single-cycle response per port
//   busy                          any request issued but not yet returned
//   err                           sticky: AES output valid disagreed with the
//                                 tag pipe
// -----------------------------------------------------------------------------
module aes_arbiter
    import ot_pkg::*;
#(
    parameter int D           = 3,
    parameter int DATA_W      = 128,
    parameter int AES_LATENCY = AES_LATENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [D-1:0]      req0_tag,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [D-1:0]      req1_tag,

    output logic              aes_in_valid,
    output logic [DATA_W-1:0] aes_in_data,
    input  logic              aes_out_valid,
    input  logic [DATA_W-1:0] aes_out_data,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic [D-1:0]      rsp0_tag,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [D-1:0]      rsp1_tag,

    output logic              busy,
    output logic              err
);

    localparam int ENTRY_W = $bits(tag_entry_t);
    localparam int BLANK_W = $clog2(AES_LATENCY + 1);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic pick_hash;
    logic grant;

`ifdef AES_ARB_ROUND_ROBIN_EN
    port_e last_grant;

    // Reset value HASH makes EXPAND win the first contended cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= HASH;
        end else if (grant) begin
            last_grant <= req1_ready ? HASH : EXPAND;
        end
    end
`endif

    // NOTE: combinational outputs get a default before any branch so that
    // every path assigns them and no latch is inferred.
    always_comb begin
        pick_hash = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef AES_ARB_ROUND_ROBIN_EN
            pick_hash = (last_grant == EXPAND);
`endif
        end else begin
            pick_hash = req1_valid;
        end
    end

    assign req0_ready = !rst && enable && req0_valid && !pick_hash;
    assign req1_ready = !rst && enable && req1_valid &&  pick_hash;
    assign grant      = req0_ready || req1_ready;

    // ------------------------------------------------------------------
    // Issue register feeding the AES pipe
    // ------------------------------------------------------------------
    logic              issue_valid;
    logic [DATA_W-1:0] issue_data;
    port_e             issue_port;
    logic [D-1:0]      issue_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid <= 1'b0;
        end else begin
            issue_valid <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            issue_data <= req1_ready ? req1_data : req0_data;
            issue_port <= req1_ready ? HASH : EXPAND;
            issue_tag  <= req1_ready ? req1_tag : req0_tag;
        end
    end

    assign aes_in_valid = issue_valid;
    assign aes_in_data  = issue_data;

    // ------------------------------------------------------------------
    // Tag pipe: loads from the issue register on the same edge the AES
    // pipe samples aes_in, so its tail lines up with aes_out.
    // ------------------------------------------------------------------
    tag_entry_t issue_entry;
    tag_entry_t tail_entry;
    logic       tail_valid;
    logic       pipe_busy;

    always_comb begin
        issue_entry        = '0;
        issue_entry.port   = issue_port;
        issue_entry.tag[D-1:0] = issue_tag;
    end

    aes_tag_pipe #(
        .DEPTH (AES_LATENCY),
        .WIDTH (ENTRY_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue_valid),
        .in_data   (issue_entry),
        .out_valid (tail_valid),
        .out_data  (tail_entry),
        .any_valid (pipe_busy)
    );

    // Tag bits above D are zero padding and intentionally dropped.
    logic unused_tag_pad;
    assign unused_tag_pad = ^tail_entry.tag;

    // ------------------------------------------------------------------
    // Responses: requesters always accept, so no back-pressure path.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            rsp0_valid <= tail_valid && (tail_entry.port == EXPAND);
            rsp1_valid <= tail_valid && (tail_entry.port == HASH);
        end
    end

    always_ff @(posedge clk) begin
        if (tail_valid) begin
            if (tail_entry.port == EXPAND) begin
                rsp0_data <= aes_out_data;
                rsp0_tag  <= tail_entry.tag[D-1:0];
            end else begin
                rsp1_data <= aes_out_data;
                rsp1_tag  <= tail_entry.tag[D-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol check. A reset empties the tag pipe but not the external AES
    // pipe, so blocks issued before the reset still emerge for up to
    // AES_LATENCY cycles; the check is blanked for that window.
    // ------------------------------------------------------------------
    logic [BLANK_W-1:0] blank_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_cnt <= BLANK_W'(AES_LATENCY);
            err       <= 1'b0;
        end else begin
            if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - BLANK_W'(1);
            end
            if ((blank_cnt == '0) && (aes_out_valid != tail_valid)) begin
                err <= 1'b1;
            end
        end
    end

    assign busy = issue_valid || pipe_busy;

endmodule
